// File: rtl/ts_capture.sv
// Event timestamp capture: samples cnt_i on each rising edge of event_i into a
// small FIFO drained over valid/ready, with sticky overflow and drop counter.
module ts_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             event_i,
  output logic [WIDTH-1:0] ts_data_o,
  output logic             ts_valid_o,
  input  logic             ts_ready_i,
  output logic [LW-1:0]    level_o,
  output logic             ovf_o,
  input  logic             clr_ovf_i,
  output logic [7:0]       drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             event_q;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic edge_det, full, pop, push, drop;

  always_comb begin
    edge_det = event_i & ~event_q;
    full     = (level_q == LW'(DEPTH));
    pop      = ts_valid_o & ts_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push     = edge_det & (~full | pop);
    drop     = edge_det & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Drop takes priority over a coincident clear.
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf_i)
        drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)
        drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      event_q    <= 1'b1;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      event_q    <= event_i;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= cnt_i;
  end

  always_comb begin
    ts_valid_o = (level_q != '0);
    ts_data_o  = ts_valid_o ? mem_q[rd_ptr_q] : '0;
    level_o    = level_q;
    ovf_o      = ovf_q;
    drop_cnt_o = drop_cnt_q;
  end

endmodule

// File: doc/ts_capture.md
# ts_capture

Event timestamp capture stage placed directly downstream of the free-running `counter`. On each rising edge of `event_i` it samples the counter value `cnt_i` and pushes it into a small FIFO. A consumer drains the FIFO through a valid/ready interface. Overflow is reported through a sticky flag and a saturating drop counter.

## Interface
Parameters:
- WIDTH, 8, timestamp width; must equal the upstream counter WIDTH
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- LW, derived as $clog2(DEPTH)+1, width of level_o

Ports:
- clk  in  1  clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- cnt_i  in  WIDTH  counter value from upstream counter cnt_o
- event_i  in  1  event strobe, already synchronous to clk
- ts_data_o  out  WIDTH  head-of-FIFO timestamp
- ts_valid_o  out  1  head entry valid
- ts_ready_i  in  1  consumer accepts head entry
- level_o  out  LW  number of stored entries, 0..DEPTH
- ovf_o  out  1  sticky overflow flag
- clr_ovf_i  in  1  synchronous clear of ovf_o and drop_cnt_o
- drop_cnt_o  out  8  saturating count of dropped events

## Operation
- Edge detect: event_q register; edge = event_i & ~event_q. event_q resets to 1, so an event held high through reset release produces no edge until it has gone low and then high again.
- Push: on an edge cycle, the value of cnt_i in that same cycle is written at the write pointer. Counter wrap-around needs no handling: the value is stored verbatim, with no extension and no unwrapping.
- Pop: occurs when ts_valid_o & ts_ready_i at a clock edge. Read pointer advances. ts_ready_i is ignored when ts_valid_o = 0.
- ts_valid_o = (level != 0). ts_data_o = mem[rd_ptr] when valid, else all zeros.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. level is tracked in an explicit counter.
- Full, edge, no pop: the event is dropped. ovf_o is set, drop_cnt_o increments (saturates at 255), and the FIFO is unchanged.
- Full, edge, pop in the same cycle: both the push and the pop occur, level stays DEPTH, and there is no drop.
- Empty, edge: push. ts_valid_o rises the next cycle. There is no same-cycle bypass.
- Not full, edge, pop in the same cycle: level is unchanged.
- clr_ovf_i: clears ovf_o and drop_cnt_o the next cycle. If a drop occurs in the same cycle as clr_ovf_i, the drop wins: ovf_o = 1 and drop_cnt_o = 1.
- reset at any time, including mid-drain: pointers, level, ovf_o and drop_cnt_o go to 0, event_q goes to 1, and FIFO contents are discarded. Memory contents need not be reset.

## Timing
- Reset values: ts_valid_o = 0, ts_data_o = 0, level_o = 0, ovf_o = 0, drop_cnt_o = 0.
- Capture latency is 1 cycle. An edge at cycle N stores cnt_i(N), and the entry is visible at the output at N+1 if the FIFO was empty.
- Pop takes effect at the clock edge. The next entry, or valid = 0, is presented in the following cycle.
- Throughput is one push and one pop per cycle. The minimum event spacing for distinct captures is 2 cycles, because event_i must go low for one cycle.
- All outputs are registered state or a combinational decode of registered state. There is no combinational path from event_i or ts_ready_i to any output.

## Test plan
- Reset, then event_i pulses at cnt_i = 5, 9, 20 with ts_ready_i = 0 -> level_o = 3; holding ts_ready_i = 1 then yields 5, 9, 20 on consecutive cycles, after which ts_valid_o = 0 and ts_data_o = 0.
- Event_i held high for 10 cycles -> exactly one entry, whose value is the cnt_i of the first high cycle.
- DEPTH = 4, ts_ready_i = 0, 6 events -> level_o = 4, ovf_o = 1, drop_cnt_o = 2, and the stored values are the first 4 timestamps. Pulsing clr_ovf_i -> ovf_o = 0 and drop_cnt_o = 0, with level_o still 4.
- FIFO full, event coinciding with a pop -> no drop, level_o = 4, and the new timestamp lands at the tail.
- cnt_i wrapping 254 → 255 → 0 → 1 with events at 255 and 1 -> output values 255 then 1, unmodified.
- Assert reset with 3 entries queued and ts_ready_i = 1 -> outputs return to 0 immediately. An event high at reset release is not captured, and the next real edge produces a single entry.
